// File: rtl/leaf_spine_switch_pkg.sv
// Shared NoC definitions for the leaf switch: address width, default tile
// address, destination extraction, route classification and a clog2 helper.
package noc_pkg;

    localparam int ADDR_W     = 6;
    localparam int MAX_DWIDTH = 64;
    localparam logic [ADDR_W-1:0] LOCAL_ID_DEFAULT = 6'd25;

    typedef enum logic [1:0] {
        ROUTE_LOCAL = 2'd0,
        ROUTE_SPINE = 2'd1,
        ROUTE_DROP  = 2'd2
    } route_kind_e;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Destination field sits in the top ADDR_W bits of a dwidth-bit flit.
    function automatic logic [ADDR_W-1:0] flit_dest(input logic [MAX_DWIDTH-1:0] flit,
                                                    input int dwidth);
        logic [MAX_DWIDTH-1:0] shifted;
        shifted = flit >> (dwidth - ADDR_W);
        return shifted[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/leaf_spine_switch_if.sv
// Bundles the NI and spine handshakes plus status of the leaf switch.
interface leaf_spine_switch_if #(
    parameter int NUM_SPINES = 4,
    parameter int DWIDTH     = 16
);
    logic [DWIDTH-1:0]              local_in_data;
    logic                           local_in_valid;
    logic                           local_in_ready;
    logic [DWIDTH-1:0]              local_out_data;
    logic                           local_out_valid;
    logic                           local_out_ready;
    logic [NUM_SPINES*DWIDTH-1:0]   spine_in_data;
    logic [NUM_SPINES-1:0]          spine_in_valid;
    logic [NUM_SPINES-1:0]          spine_in_ready;
    logic [NUM_SPINES*DWIDTH-1:0]   spine_out_data;
    logic [NUM_SPINES-1:0]          spine_out_valid;
    logic [NUM_SPINES-1:0]          spine_out_ready;
    logic [15:0]                    drop_count;
    logic [NUM_SPINES:0]            fifo_full;

    // Switch side.
    modport slave (
        input  local_in_data, local_in_valid, local_out_ready,
        input  spine_in_data, spine_in_valid, spine_out_ready,
        output local_in_ready, local_out_data, local_out_valid,
        output spine_in_ready, spine_out_data, spine_out_valid,
        output drop_count, fifo_full
    );

    // Environment side.
    modport master (
        output local_in_data, local_in_valid, local_out_ready,
        output spine_in_data, spine_in_valid, spine_out_ready,
        input  local_in_ready, local_out_data, local_out_valid,
        input  spine_in_ready, spine_out_data, spine_out_valid,
        input  drop_count, fifo_full
    );
endinterface

// File: rtl/leaf_spine_switch_fifo.sv
// Per-port input FIFO; pointers carry one extra wrap bit to tell full from empty.
module flit_fifo
    import noc_pkg::*;
#(
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DWIDTH-1:0] head_o
);
    localparam int AW = clog2(FIFO_DEPTH);

    logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Storage write and pointer advance; reset discards every stored flit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_i && !full_o) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/leaf_spine_switch.sv
// Leaf switch joining one NI port to NUM_SPINES spine links. Inputs are
// FIFO-buffered, local_out is round-robin arbitrated, spine_out is fed only
// by the local FIFO, and misaddressed spine flits are dropped and counted.
module leaf_spine_switch
    import noc_pkg::*;
#(
    parameter int                NUM_SPINES = 4,
    parameter int                DWIDTH     = 16,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] LOCAL_ID   = LOCAL_ID_DEFAULT
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    leaf_spine_switch_if.slave bus
);
    localparam int NREQ = NUM_SPINES + 1;
    localparam int PW   = clog2(NREQ);

    logic [DWIDTH-1:0]     in_data_s [NREQ];
    logic [DWIDTH-1:0]     head_s    [NREQ];
    logic [NREQ-1:0]       in_valid_s, push_s, pop_s, full_s, empty_s;
    route_kind_e           route_s   [NREQ];
    logic [ADDR_W-1:0]     dest_s    [NREQ];
    logic [NREQ-1:0]       lreq_s;
    logic [NUM_SPINES-1:0] drop_s, sreq_s, sp_load_s;
    int                    spine_sel_s;
    logic [PW-1:0]         grant_d, rr_next_s, idx_s;
    logic                  any_req_s, found_s, lo_load_s;
    logic [4:0]            ndrop_s;
    logic [16:0]           drop_sum_s;
    logic [15:0]           drop_count_d;

    logic [DWIDTH-1:0]     lo_data_q;
    logic                  lo_valid_q;
    logic [PW-1:0]         rr_ptr_q;
    logic [DWIDTH-1:0]     sp_data_q [NUM_SPINES];
    logic [NUM_SPINES-1:0] sp_valid_q;
    logic [15:0]           drop_count_q;

    assign in_data_s[0]  = bus.local_in_data;
    assign in_valid_s[0] = bus.local_in_valid;
    assign push_s        = in_valid_s & ~full_s;

    genvar g;
    generate
        for (g = 0; g < NUM_SPINES; g++) begin : g_spine_io
            assign in_data_s[g+1]  = bus.spine_in_data[g*DWIDTH +: DWIDTH];
            assign in_valid_s[g+1] = bus.spine_in_valid[g];
            assign bus.spine_out_data[g*DWIDTH +: DWIDTH] = sp_data_q[g];
        end
        for (g = 0; g < NREQ; g++) begin : g_fifo
            flit_fifo #(.DWIDTH(DWIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
                .clk    (ACLK),
                .rst_n  (ARESETn),
                .push_i (push_s[g]),
                .data_i (in_data_s[g]),
                .pop_i  (pop_s[g]),
                .full_o (full_s[g]),
                .empty_o(empty_s[g]),
                .head_o (head_s[g])
            );
        end
    endgenerate

    // Classify every FIFO head and derive local/spine requests and drops.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            dest_s[k]  = flit_dest(MAX_DWIDTH'(head_s[k]), DWIDTH);
            route_s[k] = (dest_s[k] == LOCAL_ID) ? ROUTE_LOCAL
                       : ((k == 0) ? ROUTE_SPINE : ROUTE_DROP);
            lreq_s[k]  = !empty_s[k] && (route_s[k] == ROUTE_LOCAL);
        end
        for (int j = 0; j < NUM_SPINES; j++) begin
            drop_s[j] = !empty_s[j+1] && (route_s[j+1] == ROUTE_DROP);
        end
        spine_sel_s = int'(dest_s[0]) % NUM_SPINES;
        for (int j = 0; j < NUM_SPINES; j++) begin
            sreq_s[j]    = !empty_s[0] && (route_s[0] == ROUTE_SPINE) && (spine_sel_s == j);
            sp_load_s[j] = sreq_s[j] && (!sp_valid_q[j] || bus.spine_out_ready[j]);
        end
    end

    // Round-robin search for local_out starting at rr_ptr_q.
    always_comb begin
        grant_d   = '0;
        any_req_s = 1'b0;
        idx_s     = '0;
        found_s   = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            idx_s     = PW'((int'(rr_ptr_q) + off) % NREQ);
            found_s   = lreq_s[idx_s] && !any_req_s;
            grant_d   = found_s ? idx_s : grant_d;
            any_req_s = any_req_s | found_s;
        end
        lo_load_s = any_req_s && (!lo_valid_q || bus.local_out_ready);
        rr_next_s = (grant_d == PW'(NREQ - 1)) ? '0 : grant_d + PW'(1);
    end

    // FIFO pops: granted and loaded, or dropped; saturating drop sum.
    always_comb begin
        pop_s[0] = (lo_load_s && (grant_d == '0)) || (|sp_load_s);
        for (int j = 0; j < NUM_SPINES; j++) begin
            pop_s[j+1] = (lo_load_s && (grant_d == PW'(j + 1))) || drop_s[j];
        end
        ndrop_s = 5'd0;
        for (int j = 0; j < NUM_SPINES; j++) ndrop_s = ndrop_s + 5'(drop_s[j]);
        drop_sum_s   = {1'b0, drop_count_q} + 17'(ndrop_s);
        drop_count_d = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
    end

    // local_out register, RR pointer and drop counter.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            lo_data_q    <= '0;
            lo_valid_q   <= 1'b0;
            rr_ptr_q     <= '0;
            drop_count_q <= 16'h0000;
        end else begin
            drop_count_q <= drop_count_d;
            if (lo_load_s) begin
                lo_data_q  <= head_s[grant_d];
                lo_valid_q <= 1'b1;
                rr_ptr_q   <= rr_next_s;
            end else if (bus.local_out_ready) begin
                lo_valid_q <= 1'b0;
            end
        end
    end

    // spine_out registers, each fed only by the local FIFO.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            sp_valid_q <= '0;
            for (int j = 0; j < NUM_SPINES; j++) sp_data_q[j] <= '0;
        end else begin
            for (int j = 0; j < NUM_SPINES; j++) begin
                if (sp_load_s[j]) begin
                    sp_data_q[j]  <= head_s[0];
                    sp_valid_q[j] <= 1'b1;
                end else if (bus.spine_out_ready[j]) begin
                    sp_valid_q[j] <= 1'b0;
                end
            end
        end
    end

    assign bus.local_in_ready  = ~full_s[0];
    assign bus.spine_in_ready  = ~full_s[NREQ-1:1];
    assign bus.local_out_data  = lo_data_q;
    assign bus.local_out_valid = lo_valid_q;
    assign bus.spine_out_valid = sp_valid_q;
    assign bus.drop_count      = drop_count_q;
    assign bus.fifo_full       = full_s;
endmodule

// File: tb/tb_leaf_spine_switch.sv
// Directed, table-driven bench for leaf_spine_switch (4 spines, 16-bit flits,
// LOCAL_ID 25). Inputs change 1 time unit after a rising edge, outputs are
// sampled at that same point.
module tb_leaf_spine_switch;
    localparam int NS = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    leaf_spine_switch_if #(.NUM_SPINES(NS), .DWIDTH(DW)) bus ();

    leaf_spine_switch #(
        .NUM_SPINES(NS), .DWIDTH(DW), .FIFO_DEPTH(4), .LOCAL_ID(6'd25)
    ) dut (
        .ACLK   (clk),
        .ARESETn(rst_n),
        .bus    (bus)
    );

    typedef struct {
        int          src;   // 0 = local, 1..4 = spine src-1
        logic [15:0] flit;
        int          port;  // 0 = local_out, 1..4 = spine_out port-1, 5 = dropped
    } vec_t;

    vec_t vecs [9];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_drops;
    int   tally [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_src(input int src, input logic [15:0] f, input logic v);
        if (src == 0) begin
            bus.local_in_data  = f;
            bus.local_in_valid = v;
        end else begin
            bus.spine_in_data[(src-1)*DW +: DW] = f;
            bus.spine_in_valid[src-1]           = v;
        end
    endtask

    task automatic idle_inputs();
        bus.local_in_data  = 16'h0000;
        bus.local_in_valid = 1'b0;
        bus.spine_in_data  = '0;
        bus.spine_in_valid = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.local_out_ready = 1'b1;
        bus.spine_out_ready = '1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int   sent;
        logic rdy;
        logic [4:0] exp_v;
        int   seen;

        vecs[0] = '{0, 16'h6400, 0};  // loopback, dest 25
        vecs[1] = '{0, 16'h1433, 2};  // dest 5  -> spine 1
        vecs[2] = '{0, 16'hFBFF, 3};  // dest 62 -> spine 2
        vecs[3] = '{0, 16'h0C01, 4};  // dest 3  -> spine 3
        vecs[4] = '{1, 16'h6411, 0};  // spine 0, dest 25 -> local
        vecs[5] = '{4, 16'h67FF, 0};  // spine 3, dest 25 -> local
        vecs[6] = '{3, 16'h6001, 5};  // spine 2, dest 24 -> drop
        vecs[7] = '{2, 16'h6800, 5};  // spine 1, dest 26 -> drop
        vecs[8] = '{0, 16'h0000, 1};  // dest 0 -> spine 0

        do_reset();
        chk("rst_out_valid", {bus.spine_out_valid, bus.local_out_valid}, 32'h0);
        chk("rst_local_data", bus.local_out_data, 32'h0);
        chk("rst_spine_data", bus.spine_out_data, 32'h0);
        chk("rst_drop_count", bus.drop_count, 32'h0);
        chk("rst_in_ready", {bus.spine_in_ready, bus.local_in_ready}, 32'h1F);
        chk("rst_fifo_full", bus.fifo_full, 32'h0);

        // Single-flit routing table: nothing after the accepting edge, the
        // flit registered one edge later (consumed downstream at N+2).
        exp_drops = 0;
        for (int i = 0; i < 9; i++) begin
            drive_src(vecs[i].src, vecs[i].flit, 1'b1);
            step();
            drive_src(vecs[i].src, 16'h0000, 1'b0);
            chk("vec_early_valid", {bus.spine_out_valid, bus.local_out_valid}, 32'h0);
            step();
            exp_v = (vecs[i].port <= 4) ? (5'b00001 << vecs[i].port) : 5'b00000;
            chk("vec_valid", {bus.spine_out_valid, bus.local_out_valid}, 32'(exp_v));
            if (vecs[i].port == 0) begin
                chk("vec_local_data", bus.local_out_data, 32'(vecs[i].flit));
            end else if (vecs[i].port <= 4) begin
                chk("vec_spine_data", bus.spine_out_data[(vecs[i].port-1)*DW +: DW],
                    32'(vecs[i].flit));
            end else begin
                exp_drops++;
            end
            chk("vec_drops", bus.drop_count, 32'(exp_drops));
            step();
            step();
        end

        // Back-to-back local flits to dest 0..3.
        for (int k = 0; k < 5; k++) begin
            if (k < 4) drive_src(0, 16'((k << 10) | 16'h00AA), 1'b1);
            else       drive_src(0, 16'h0000, 1'b0);
            step();
            exp_v = (k == 0) ? 5'b00000 : (5'b00001 << (k - 1));
            chk("b2b_valid", bus.spine_out_valid, 32'(exp_v[3:0]));
            if (k > 0) chk("b2b_data", bus.spine_out_data[(k-1)*DW +: DW],
                           32'(((k - 1) << 10) | 16'h00AA));
        end

        // Round-robin: all five sources stream loopback flits.
        do_reset();
        for (int s = 0; s < 16; s++) tally[s] = 0;
        for (int s = 0; s <= NS; s++) drive_src(s, 16'(16'h6400 | s), 1'b1);
        step();
        for (int e = 1; e <= 15; e++) begin
            step();
            chk("rr_valid", bus.local_out_valid, 32'h1);
            chk("rr_order", bus.local_out_data, 32'(16'h6400 | ((e - 1) % 5)));
            tally[bus.local_out_data[3:0]]++;
        end
        chk("rr_no_spine", bus.spine_out_valid, 32'h0);
        for (int s = 0; s <= NS; s++) chk("rr_share", 32'(tally[s]), 32'd3);

        // Backpressure on spine_out 2 with five local flits to dest 2.
        do_reset();
        bus.spine_out_ready[2] = 1'b0;
        sent = 0;
        for (int t = 0; t < 20 && sent < 5; t++) begin
            drive_src(0, 16'(16'h0800 | (sent + 1)), 1'b1);
            rdy = bus.local_in_ready;
            step();
            if (rdy) sent++;
        end
        drive_src(0, 16'h0000, 1'b0);
        chk("bp_sent", 32'(sent), 32'd5);
        step();
        step();
        chk("bp_valid", bus.spine_out_valid, 32'h4);
        chk("bp_hold_data", bus.spine_out_data[2*DW +: DW], 32'h0801);
        chk("bp_fifo_full", bus.fifo_full, 32'h1);
        chk("bp_in_ready", bus.local_in_ready, 32'h0);
        step();
        chk("bp_hold_data2", bus.spine_out_data[2*DW +: DW], 32'h0801);
        bus.spine_out_ready[2] = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            step();
            chk("bp_drain_valid", bus.spine_out_valid[2], 32'h1);
            chk("bp_drain_data", bus.spine_out_data[2*DW +: DW], 32'(16'h0800 | k));
        end
        step();
        chk("bp_drained", bus.spine_out_valid, 32'h0);
        chk("bp_ready_back", bus.local_in_ready, 32'h1);

        // Drops from spine 1, then saturation.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive_src(2, 16'(16'h1C00 | k), 1'b1);
            step();
            chk("drop_no_local", bus.local_out_valid, 32'h0);
        end
        idle_inputs();
        step();
        step();
        chk("drop_count3", bus.drop_count, 32'd3);
        chk("drop_no_local2", bus.local_out_valid, 32'h0);
        for (int s = 1; s <= NS; s++) drive_src(s, 16'h1C00, 1'b1);
        repeat (16400) step();
        idle_inputs();
        step();
        step();
        chk("drop_saturated", bus.drop_count, 32'hFFFF);
        drive_src(1, 16'h1C00, 1'b1);
        step();
        idle_inputs();
        step();
        step();
        chk("drop_stays_sat", bus.drop_count, 32'hFFFF);

        // Asynchronous reset while FIFOs hold data and outputs are stalled.
        do_reset();
        bus.local_out_ready = 1'b0;
        bus.spine_out_ready = '0;
        drive_src(0, 16'h0805, 1'b1);
        drive_src(1, 16'h6455, 1'b1);
        drive_src(4, 16'h1C07, 1'b1);
        repeat (6) step();
        chk("mid_pre_drops", bus.drop_count, 32'd5);
        chk("mid_pre_valid", {bus.spine_out_valid, bus.local_out_valid}, 32'h09);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("mid_rst_valid", {bus.spine_out_valid, bus.local_out_valid}, 32'h0);
        chk("mid_rst_drops", bus.drop_count, 32'h0);
        chk("mid_rst_full", bus.fifo_full, 32'h0);
        bus.local_out_ready = 1'b1;
        bus.spine_out_ready = '1;
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.local_out_valid || (|bus.spine_out_valid)) seen++;
        end
        chk("post_rst_no_stale", 32'(seen), 32'd0);
        chk("post_rst_in_ready", {bus.spine_in_ready, bus.local_in_ready}, 32'h1F);
        chk("post_rst_drops", bus.drop_count, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
